memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- MEM stage of the 5-stage core; consumes the EX-stage registered outputs (alu_result, rs2E, write_regE, info_loadE, info_storeE, dstreg_addrE).
- Issues loads and stores on a req/ack data-memory bus and stalls the pipeline until the bus acknowledges.
- Formats store byte lanes and load extension, and registers results into the WB stage.
- Drives forward_data_writemem back to the EX-stage forwarding muxes.

Parameters:
TIMEOUT_CYCLES, 256, cycles in WAIT without dmem_ack before abort; 0 disables timeout

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
alu_result  in  32  EX result / effective address
rs2E  in  32  store data
write_regE  in  1  EX instruction writes register file
info_loadE  in  3  load kind: NOTLOAD=0, LB=1, LH=2, LW=3, LBU=4, LHU=5
info_storeE  in  2  store kind: NOTSTORE=0, SB=1, SH=2, SW=3
dstreg_addrE  in  5  destination register
dmem_req  out  1  bus request, held until ack
dmem_we  out  1  1=store, 0=load
dmem_addr  out  32  word address, {alu_result[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read word, valid with ack
dmem_ack  in  1  one-cycle completion
stall_mem  out  1  freeze PC/IF/ID/EX registers
forward_data_writemem  out  32  combinational = alu_result
wb_data  out  32  registered result to WB
write_regM  out  1  registered write enable to WB
dstreg_addrM  out  5  registered destination
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_data, write_regM, dstreg_addrM, bus_err, timeout counter all 0. Reset mid-WAIT drops dmem_req the next cycle; a late ack is ignored.
- access = (info_loadE!=0) | (info_storeE!=0). If both are nonzero, the load wins and the store is ignored.
- States: IDLE, WAIT.
- IDLE, no access:
  - wb_data<=alu_result, write_regM<=write_regE, dstreg_addrM<=dstreg_addrE.
  - Latency 1, stall_mem=0.
- IDLE, access:
  - stall_mem=1 combinationally.
  - Latch dmem_addr, dmem_we, dmem_be, dmem_wdata, and the load kind and addr[1:0] internally.
  - dmem_req<=1; write_regM<=0 (bubble to WB); go to WAIT.
- WAIT, stall_mem=1:
  - Upstream holds its inputs stable. dmem_req and the bus outputs are held.
  - On dmem_ack:
    - dmem_req<=0; stall_mem=0 that cycle; go to IDLE.
    - Store: write_regM<=0.
    - Load: wb_data<=extracted rdata, write_regM<=write_regE, dstreg_addrM<=dstreg_addrE.
  - Minimum memory op: 2 cycles (ack in the first WAIT cycle).
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2E[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2E[15:0]}}.
  - SW: be=4'b1111, wdata=rs2E.
  - Loads drive be=4'b1111.
- Load extract:
  - Byte select by addr[1:0]; half select by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Misalignment (feature off): addr[0] is ignored for halves; addr[1:0] is ignored for words.
- Timeout:
  - Counter increments each WAIT cycle without ack and clears on leaving WAIT.
  - At TIMEOUT_CYCLES-1: dmem_req<=0, bus_err<=1 for one cycle, write_regM<=0, go to IDLE, release stall.
  - If ack and timeout coincide, ack wins.
- An ack in IDLE is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: in IDLE, a half access with addr[0]=1 or a word access with addr[1:0]!=0 is not issued. The block stays IDLE, write_regM<=0, and the extra output misalign_exc (1 bit) pulses for one cycle; no stall.
- Undefined: misalign_exc is absent and addresses are truncated as above.

Test Plan:
- ALU op alu_result=0x1234, write_regE=1, dst=5 -> next cycle wb_data=0x1234, write_regM=1, dstreg_addrM=5; stall_mem never rises.
- SB addr=0x103, rs2E=0xAABBCCDD, ack after 3 cycles -> dmem_addr=0x100, be=4'b1000, wdata=0xDDDDDDDD, we=1; stall_mem high 4 cycles; write_regM=0.
- LB addr=0x102, rdata=0x0080FF00, ack in first WAIT cycle -> wb_data=0xFFFFFF80. Same access as LBU -> 0x00000080. LH addr=0x102 -> 0x00000080.
- LW addr=0x200, no ack, TIMEOUT_CYCLES=4 -> dmem_req drops after 4 WAIT cycles, bus_err pulses once, stall releases, write_regM=0.
- rst asserted during WAIT, then ack arrives -> dmem_req=0 the next cycle, outputs 0, ack ignored.
- MISALIGN_TRAP_EN, LW addr=0x102 -> dmem_req stays 0, misalign_exc pulses 1 cycle, write_regM=0.

Source files
------------

// File: rtl/memory_access.sv
// memory_access: MEM stage of the 5-stage core.
// Issues loads/stores on a req/ack data-memory bus, stalls the pipeline while
// the bus is busy, formats store byte lanes and load extension, and registers
// the stage result towards WB.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alu_result, rs2E         EX result / effective address, store data
//   write_regE, info_loadE,
//   info_storeE, dstreg_addrE EX-stage control for the instruction in MEM
//   dmem_req/we/addr/be/wdata data-memory request (registered, held until ack)
//   dmem_rdata, dmem_ack     read data and one-cycle completion
//   stall_mem                combinational freeze of PC/IF/ID/EX
//   forward_data_writemem    combinational forward of alu_result to EX
//   wb_data, write_regM,
//   dstreg_addrM             registered result to WB
//   bus_err                  one-cycle pulse when an access times out
//   misalign_exc             one-cycle pulse on a misaligned access
//                            (only with MISALIGN_TRAP_EN defined)
//
// Build option: MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses are not issued and raise misalign_exc instead of being truncated.
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2E,
  input  logic        write_regE,
  input  logic [2:0]  info_loadE,
  input  logic [1:0]  info_storeE,
  input  logic [4:0]  dstreg_addrE,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic [31:0] forward_data_writemem,
  output logic [31:0] wb_data,
  output logic        write_regM,
  output logic [4:0]  dstreg_addrM,
  output logic        bus_err
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_exc
`endif
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LW   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       kind_q, kind_d;
  logic [1:0]       off_q, off_d;

  logic        req_d, we_d, write_reg_d, bus_err_d;
  logic [31:0] addr_d, wdata_d, wb_data_d;
  logic [3:0]  be_d;
  logic [4:0]  dst_d;

  logic        is_load, is_store, access, timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign is_load  = info_loadE != LD_NONE;
  assign is_store = info_storeE != 2'd0;
  assign access   = is_load | is_store;

  assign forward_data_writemem = alu_result;

  // Timeout fires on the last permitted WAIT cycle; TIMEOUT_CYCLES=0 disables it.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
  logic is_half, is_word, misaligned, mis_d;

  // Misalignment check on the effective access kind (load has priority).
  always_comb begin
    is_half    = is_load ? ((info_loadE == LD_LH) || (info_loadE == LD_LHU))
                         : (info_storeE == ST_SH);
    is_word    = is_load ? (info_loadE == LD_LW) : (info_storeE == ST_SW);
    misaligned = (is_half && alu_result[0]) || (is_word && (alu_result[1:0] != 2'b00));
  end
`endif

  // Store lane formatting; loads enable all four lanes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = rs2E;
    if (!is_load) begin
      case (info_storeE)
        ST_SB: begin
          st_be    = 4'b0001 << alu_result[1:0];
          st_wdata = {4{rs2E[7:0]}};
        end
        ST_SH: begin
          st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{rs2E[15:0]}};
        end
        ST_SW: begin
          st_be    = 4'b1111;
          st_wdata = rs2E;
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = rs2E;
        end
      endcase
    end
  end

  // Load extraction from the latched kind and byte offset.
  always_comb begin
    ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (kind_q)
      LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LD_LBU:  ld_data = {24'd0, ld_byte};
      LD_LHU:  ld_data = {16'd0, ld_half};
      LD_LW:   ld_data = dmem_rdata;
      default: ld_data = dmem_rdata;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
    off_d       = off_q;
    req_d       = dmem_req;
    we_d        = dmem_we;
    addr_d      = dmem_addr;
    be_d        = dmem_be;
    wdata_d     = dmem_wdata;
    wb_data_d   = wb_data;
    write_reg_d = write_regM;
    dst_d       = dstreg_addrM;
    bus_err_d   = 1'b0;
    stall_mem   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef MISALIGN_TRAP_EN
        if (access && misaligned) begin
          write_reg_d = 1'b0;
          mis_d       = 1'b1;
        end else
`endif
        if (access) begin
          stall_mem   = 1'b1;
          state_d     = WAIT;
          req_d       = 1'b1;
          we_d        = !is_load;
          addr_d      = {alu_result[31:2], 2'b00};
          be_d        = st_be;
          wdata_d     = st_wdata;
          kind_d      = is_load ? info_loadE : LD_NONE;
          off_d       = alu_result[1:0];
          write_reg_d = 1'b0;
        end else begin
          wb_data_d   = alu_result;
          write_reg_d = write_regE;
          dst_d       = dstreg_addrE;
        end
      end

      WAIT: begin
        // Ack has priority over a coincident timeout.
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          if (kind_q != LD_NONE) begin
            wb_data_d   = ld_data;
            write_reg_d = write_regE;
            dst_d       = dstreg_addrE;
          end else begin
            write_reg_d = 1'b0;
          end
        end else if (timeout_hit) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          cnt_d       = '0;
          bus_err_d   = 1'b1;
          write_reg_d = 1'b0;
        end else begin
          stall_mem = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      kind_q       <= LD_NONE;
      off_q        <= 2'b00;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_be      <= 4'd0;
      dmem_wdata   <= 32'd0;
      wb_data      <= 32'd0;
      write_regM   <= 1'b0;
      dstreg_addrM <= 5'd0;
      bus_err      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kind_q       <= kind_d;
      off_q        <= off_d;
      dmem_req     <= req_d;
      dmem_we      <= we_d;
      dmem_addr    <= addr_d;
      dmem_be      <= be_d;
      dmem_wdata   <= wdata_d;
      wb_data      <= wb_data_d;
      write_regM   <= write_reg_d;
      dstreg_addrM <= dst_d;
      bus_err      <= bus_err_d;
`ifdef MISALIGN_TRAP_EN
      misalign_exc <= mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases with literal
// expectations, then randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_memory_access;

  localparam int unsigned T = 4;

  logic        clk;
  logic        rst;
  logic [31:0] alu_result;
  logic [31:0] rs2E;
  logic        write_regE;
  logic [2:0]  info_loadE;
  logic [1:0]  info_storeE;
  logic [4:0]  dstreg_addrE;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall_mem;
  logic [31:0] forward_data_writemem;
  logic [31:0] wb_data;
  logic        write_regM;
  logic [4:0]  dstreg_addrM;
  logic        bus_err;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  memory_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .alu_result(alu_result),
    .rs2E(rs2E),
    .write_regE(write_regE),
    .info_loadE(info_loadE),
    .info_storeE(info_storeE),
    .dstreg_addrE(dstreg_addrE),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .stall_mem(stall_mem),
    .forward_data_writemem(forward_data_writemem),
    .wb_data(wb_data),
    .write_regM(write_regM),
    .dstreg_addrM(dstreg_addrM),
    .bus_err(bus_err)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_exc(misalign_exc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid = 1'b0;
  bit          m_busy = 1'b0;
  int          m_waited = 0;
  bit          m_is_load = 1'b0;
  logic [2:0]  m_kind = 3'd0;
  logic [1:0]  m_off = 2'd0;
  logic        e_req, e_we, e_wreg, e_err, e_mis;
  logic [31:0] e_addr, e_wdata, e_wb;
  logic [3:0]  e_be;
  logic [4:0]  e_dst;
  bit          e_wb_fresh = 1'b0;

  function automatic logic [31:0] extract(input logic [2:0] kind, input logic [1:0] off,
                                          input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'h0000_00FF;
    h = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
    case (kind)
      3'd1:    return b - ((b & 32'h80) << 1);
      3'd2:    return h - ((h & 32'h8000) << 1);
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic void fmt_store(input logic [1:0] kind, input logic [31:0] a,
                                    input logic [31:0] d, output logic [3:0] be,
                                    output logic [31:0] wd);
    case (kind)
      2'd1: begin be = 4'(32'd1 << a[1:0]); wd = (d & 32'hFF) * 32'h0101_0101; end
      2'd2: begin be = 4'(32'd3 << (a[1:0] & 2'b10)); wd = (d & 32'hFFFF) * 32'h0001_0001; end
      default: begin be = 4'hF; wd = d; end
    endcase
  endfunction

  function automatic bit in_access();
    return (info_loadE != 3'd0) || (info_storeE != 2'd0);
  endfunction

  function automatic bit in_misaligned();
`ifdef MISALIGN_TRAP_EN
    int width;
    if (info_loadE != 3'd0)
      width = (info_loadE == 3'd2 || info_loadE == 3'd5) ? 2 : (info_loadE == 3'd3) ? 4 : 1;
    else
      width = (info_storeE == 2'd2) ? 2 : (info_storeE == 2'd3) ? 4 : 1;
    return (int'(alu_result[1:0]) % width) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit timed_out();
    return (T != 0) && (m_waited == int'(T) - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_busy = 1'b0; m_waited = 0;
      e_req = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_be = 4'd0; e_wdata = 32'd0;
      e_wb = 32'd0; e_wreg = 1'b0; e_dst = 5'd0; e_err = 1'b0; e_mis = 1'b0;
      e_wb_fresh = 1'b1;
    end else if (m_valid) begin
      e_err = 1'b0;
      e_mis = 1'b0;
      if (!m_busy) begin
        if (in_access() && in_misaligned()) begin
          e_wreg = 1'b0; e_mis = 1'b1; e_wb_fresh = 1'b0;
        end else if (in_access()) begin
          m_busy = 1'b1; m_waited = 0;
          m_is_load = info_loadE != 3'd0;
          m_kind = info_loadE;
          m_off = alu_result[1:0];
          e_req = 1'b1; e_we = !m_is_load;
          e_addr = alu_result & ~32'h3;
          if (m_is_load) begin e_be = 4'hF; e_wdata = rs2E; end
          else fmt_store(info_storeE, alu_result, rs2E, e_be, e_wdata);
          e_wreg = 1'b0; e_wb_fresh = 1'b0;
        end else begin
          e_wb = alu_result; e_wreg = write_regE; e_dst = dstreg_addrE; e_wb_fresh = 1'b1;
        end
      end else if (dmem_ack) begin
        m_busy = 1'b0; e_req = 1'b0;
        if (m_is_load) begin
          e_wb = extract(m_kind, m_off, dmem_rdata);
          e_wreg = write_regE; e_dst = dstreg_addrE; e_wb_fresh = 1'b1;
        end else begin
          e_wreg = 1'b0; e_wb_fresh = 1'b0;
        end
      end else if (timed_out()) begin
        m_busy = 1'b0; e_req = 1'b0; e_err = 1'b1; e_wreg = 1'b0; e_wb_fresh = 1'b0;
      end else begin
        m_waited++;
      end
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("dmem_req", dmem_req, e_req);
      if (e_req) begin
        check("dmem_addr", dmem_addr, e_addr);
        check("dmem_we", dmem_we, e_we);
        check("dmem_be", dmem_be, e_be);
        if (e_we) check("dmem_wdata", dmem_wdata, e_wdata);
      end
      check("write_regM", write_regM, e_wreg);
      check("bus_err", bus_err, e_err);
      if (e_wb_fresh) begin
        check("wb_data", wb_data, e_wb);
        check("dstreg_addrM", dstreg_addrM, e_dst);
      end
      check("forward", forward_data_writemem, alu_result);
      if (!rst) begin
        if (!m_busy) check("stall_idle", stall_mem, in_access() && !in_misaligned());
        else check("stall_wait", stall_mem, !(dmem_ack || timed_out()));
      end
`ifdef MISALIGN_TRAP_EN
      check("misalign_exc", misalign_exc, e_mis);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [2:0] l, input logic [1:0] s, input logic [4:0] r);
    alu_result = a; rs2E = d; write_regE = w; info_loadE = l; info_storeE = s; dstreg_addrE = r;
  endtask

  task automatic do_load(input string name, input logic [2:0] kind, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] expv);
    set_op(a, 32'd0, 1'b1, kind, 2'd0, 5'd9);
    dmem_rdata = rd;
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    set_op(32'd0, 32'd0, 1'b0, 3'd0, 2'd0, 5'd0);
    @(negedge clk);
    check(name, wb_data, expv);
    check({name, "_wreg"}, write_regM, 1'b1);
    tick();
  endtask

  int n_stall, n_req, n_err;

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    set_op(32'd0, 32'd0, 1'b0, 3'd0, 2'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req", dmem_req, 1'b0);
    check("rst_wreg", write_regM, 1'b0);
    check("rst_wb", wb_data, 32'd0);
    check("rst_dst", dstreg_addrM, 5'd0);
    check("rst_err", bus_err, 1'b0);
    check("rst_be", dmem_be, 4'd0);
    tick();
    rst = 1'b0;

    // Plain ALU op.
    set_op(32'h1234, 32'd0, 1'b1, 3'd0, 2'd0, 5'd5);
    @(negedge clk);
    check("alu_stall", stall_mem, 1'b0);
    tick();
    @(negedge clk);
    check("alu_wb", wb_data, 32'h1234);
    check("alu_wreg", write_regM, 1'b1);
    check("alu_dst", dstreg_addrM, 5'd5);
    tick();

    // SB with ack in the fourth WAIT cycle.
    set_op(32'h103, 32'hAABB_CCDD, 1'b0, 3'd0, 2'd1, 5'd7);
    n_stall = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (stall_mem) n_stall++;
      if (c == 1) begin
        check("sb_addr", dmem_addr, 32'h100);
        check("sb_be", dmem_be, 4'b1000);
        check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
        check("sb_we", dmem_we, 1'b1);
      end
      tick();
      dmem_ack = (c == 3);
    end
    set_op(32'd0, 32'd0, 1'b0, 3'd0, 2'd0, 5'd0);
    @(negedge clk);
    check("sb_stall_cycles", n_stall, 4);
    check("sb_wreg", write_regM, 1'b0);
    check("sb_req_drop", dmem_req, 1'b0);
    tick();

    // Load extraction.
    do_load("lb", 3'd1, 32'h102, 32'h0080_FF00, 32'hFFFF_FF80);
    do_load("lbu", 3'd4, 32'h102, 32'h0080_FF00, 32'h0000_0080);
    do_load("lh", 3'd2, 32'h102, 32'h0080_FF00, 32'h0000_0080);
    do_load("lhu_neg", 3'd5, 32'h100, 32'h1234_8001, 32'h0000_8001);
    do_load("lh_neg", 3'd2, 32'h100, 32'h1234_8001, 32'hFFFF_8001);

    // LW that never gets an ack.
    set_op(32'h200, 32'd0, 1'b1, 3'd3, 2'd0, 5'd3);
    n_req = 0; n_err = 0; n_stall = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (dmem_req) n_req++;
      if (bus_err) n_err++;
      if (c < 5 && stall_mem) n_stall++;
      if (c == 5) check("to_wreg", write_regM, 1'b0);
      tick();
      if (c == 4) set_op(32'd0, 32'd0, 1'b0, 3'd0, 2'd0, 5'd0);
    end
    check("to_req_cycles", n_req, 4);
    check("to_err_pulses", n_err, 1);
    check("to_stall_cycles", n_stall, 4);

    // Reset while waiting, then a late ack.
    set_op(32'h300, 32'd0, 1'b1, 3'd3, 2'd0, 5'd4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    set_op(32'h55, 32'd0, 1'b0, 3'd0, 2'd0, 5'd0);
    @(negedge clk);
    check("rstw_req", dmem_req, 1'b0);
    check("rstw_wb", wb_data, 32'd0);
    check("rstw_wreg", write_regM, 1'b0);
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("rstw_req2", dmem_req, 1'b0);
    check("rstw_wb2", wb_data, 32'h55);
    tick();

`ifdef MISALIGN_TRAP_EN
    set_op(32'h102, 32'd0, 1'b1, 3'd3, 2'd0, 5'd6);
    @(negedge clk);
    check("mis_stall", stall_mem, 1'b0);
    tick();
    set_op(32'd0, 32'd0, 1'b0, 3'd0, 2'd0, 5'd0);
    @(negedge clk);
    check("mis_req", dmem_req, 1'b0);
    check("mis_exc", misalign_exc, 1'b1);
    check("mis_wreg", write_regM, 1'b0);
    tick();
    @(negedge clk);
    check("mis_exc_clear", misalign_exc, 1'b0);
    tick();
`endif

    // Randomized traffic; upstream holds its inputs while an access is pending.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      dmem_rdata = $urandom;
      if (m_busy) begin
        dmem_ack = ($urandom_range(0, 3) == 0);
      end else begin
        dmem_ack = ($urandom_range(0, 7) == 0);
        alu_result = $urandom;
        rs2E = $urandom;
        write_regE = 1'($urandom_range(0, 1));
        dstreg_addrE = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
          0: begin info_loadE = 3'd0; info_storeE = 2'd0; end
          1: begin info_loadE = 3'($urandom_range(1, 5)); info_storeE = 2'd0; end
          2: begin info_loadE = 3'd0; info_storeE = 2'($urandom_range(1, 3)); end
          default: begin info_loadE = 3'($urandom_range(1, 5)); info_storeE = 2'($urandom_range(1, 3)); end
        endcase
      end
      tick();
    end
    rst = 1'b0;
    dmem_ack = 1'b0;
    set_op(32'd0, 32'd0, 1'b0, 3'd0, 2'd0, 5'd0);
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
